// File: rtl/pipelined_control_unit_if.sv
// Bundle of ID-stage inputs and registered pipeline control outputs for the TSC control unit.
interface pipelined_control_unit_if #(
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [3:0]        opcode;
  logic [5:0]        func_code;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ext_stall;
  logic              flush;
  logic              load_use_stall;
  logic              ex_alu_src;
  logic [1:0]        ex_alu_op;
  logic              ex_is_branch;
  logic              mem_read;
  logic              mem_write;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic              wb_pc_to_reg;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_wwd;
  logic              halted;
  logic [CNT_W-1:0]  num_inst;

  modport master (
    output id_valid, opcode, func_code, id_rs, id_rt, id_rd, ext_stall, flush,
    input  load_use_stall, ex_alu_src, ex_alu_op, ex_is_branch, mem_read, mem_write,
           wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_dest, wb_wwd, halted, num_inst
  );

  modport slave (
    input  id_valid, opcode, func_code, id_rs, id_rt, id_rd, ext_stall, flush,
    output load_use_stall, ex_alu_src, ex_alu_op, ex_is_branch, mem_read, mem_write,
           wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_dest, wb_wwd, halted, num_inst
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined TSC control unit: decodes at ID, carries control through PIPE_DEPTH stages,
// handles load-use stall, flush, external stall, HLT latching and retire counting.
//
// state  | meaning
// S_RUN  | pipeline advances normally
// S_HALT | HLT has retired; every stage loads bubbles until reset
module pipelined_control_unit #(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 2,
  parameter int CNT_W      = 16
) (
  input logic                     clk,
  input logic                     reset,
  pipelined_control_unit_if.slave bus
);
  localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_BGZ = 4'd2,  OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4,  OP_ORI = 4'd5,  OP_LHI = 4'd6,  OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8,  OP_JMP = 4'd9,  OP_JAL = 4'd10, OP_ALU = 4'd15;
  localparam logic [5:0] F_ADD = 6'd0, F_SUB = 6'd1, F_AND = 6'd2, F_ORR = 6'd3;
  localparam logic [5:0] F_NOT = 6'd4, F_TCP = 6'd5, F_SHL = 6'd6, F_SHR = 6'd7;
  localparam logic [5:0] F_JPR = 6'd25, F_JRL = 6'd26, F_WWD = 6'd28, F_HLT = 6'd29;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  typedef struct packed {
    logic              valid;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              is_branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              pc_to_reg;
    logic              wwd;
    logic              hlt;
    logic [REG_AW-1:0] dest;
  } ctrl_t;

  state_t           state_q, state_d;
  ctrl_t            stg_q [1:PIPE_DEPTH];
  ctrl_t            stg_d [1:PIPE_DEPTH];
  logic [CNT_W-1:0] num_inst_q, num_inst_d;
  ctrl_t            id_ctrl;
  logic             reads_rt;
  logic             hazard;

  always_comb begin
    id_ctrl       = '0;
    id_ctrl.valid = 1'b1;
    reads_rt      = 1'b0;
    case (bus.opcode)
      OP_ADI, OP_ORI, OP_LHI: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_ctrl.dest      = bus.id_rt;
        id_ctrl.alu_op    = (bus.opcode == OP_ORI) ? 2'd2 :
                            (bus.opcode == OP_LHI) ? 2'd3 : 2'd0;
      end
      OP_LWD: begin
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.dest       = bus.id_rt;
      end
      OP_SWD: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_ctrl.dest      = bus.id_rt;
        reads_rt          = 1'b1;
      end
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        id_ctrl.is_branch = 1'b1;
        id_ctrl.dest      = bus.id_rt;
        reads_rt          = (bus.opcode == OP_BNE) || (bus.opcode == OP_BEQ);
      end
      OP_JMP: id_ctrl.dest = bus.id_rt;
      OP_JAL: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.pc_to_reg = 1'b1;
        id_ctrl.dest      = REG_AW'(2);
      end
      OP_ALU: begin
        reads_rt       = 1'b1;
        id_ctrl.alu_op = 2'd1;
        id_ctrl.dest   = bus.id_rd;
        case (bus.func_code)
          F_ADD, F_SUB, F_AND, F_ORR, F_NOT, F_TCP, F_SHL, F_SHR: id_ctrl.reg_write = 1'b1;
          F_JPR: ;
          F_JRL: begin
            id_ctrl.reg_write = 1'b1;
            id_ctrl.pc_to_reg = 1'b1;
            id_ctrl.dest      = REG_AW'(2);
          end
          F_WWD: id_ctrl.wwd = 1'b1;
          F_HLT: id_ctrl.hlt = 1'b1;
          default: begin
            id_ctrl       = '0;
            id_ctrl.valid = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign hazard = stg_q[1].valid && stg_q[1].mem_read &&
                  ((stg_q[1].dest == bus.id_rs) || (reads_rt && (stg_q[1].dest == bus.id_rt)));

  // A flush only squashes ID when the pipe is actually moving this edge.
  assign bus.load_use_stall = hazard && bus.id_valid && (state_q == S_RUN) && !reset &&
                              !(bus.flush && !bus.ext_stall);

  always_comb begin
    stg_d      = stg_q;
    state_d    = state_q;
    num_inst_d = num_inst_q;
    case (state_q)
      S_HALT: begin
        for (int i = 1; i <= PIPE_DEPTH; i++) stg_d[i] = '0;
      end
      default: begin
        if (!bus.ext_stall) begin
          stg_d[1] = (bus.id_valid && !bus.flush && !hazard) ? id_ctrl : '0;
          for (int i = 2; i <= PIPE_DEPTH; i++) stg_d[i] = stg_q[i-1];
          if (stg_q[PIPE_DEPTH-1].valid) begin
            num_inst_d = num_inst_q + CNT_W'(1);
            if (stg_q[PIPE_DEPTH-1].hlt) state_d = S_HALT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      num_inst_q <= '0;
      for (int i = 1; i <= PIPE_DEPTH; i++) stg_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
      stg_q      <= stg_d;
    end
  end

  assign bus.ex_alu_src    = stg_q[1].alu_src;
  assign bus.ex_alu_op     = stg_q[1].alu_op;
  assign bus.ex_is_branch  = stg_q[1].is_branch;
  assign bus.mem_read      = stg_q[PIPE_DEPTH-1].mem_read;
  assign bus.mem_write     = stg_q[PIPE_DEPTH-1].mem_write;
  assign bus.wb_reg_write  = stg_q[PIPE_DEPTH].reg_write;
  assign bus.wb_mem_to_reg = stg_q[PIPE_DEPTH].mem_to_reg;
  assign bus.wb_pc_to_reg  = stg_q[PIPE_DEPTH].pc_to_reg;
  assign bus.wb_dest       = stg_q[PIPE_DEPTH].dest;
  assign bus.wb_wwd        = stg_q[PIPE_DEPTH].wwd;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.num_inst      = num_inst_q;
endmodule
